// File: rtl/pcap_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the pcap record-header generator.
package pcap_pkg;

  localparam int PCAP_MAX_SNAPLEN = 65535;

  typedef struct packed {
    logic [31:0] ts_sec;
    logic [31:0] ts_frac;
    logic [31:0] incl_len;
    logic [31:0] orig_len;
  } pcap_rec_t;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_PKT  = 1'b1
  } cap_state_t;

  typedef enum logic [2:0] {
    O_IDLE = 3'd0,
    O_SEC  = 3'd1,
    O_FRAC = 3'd2,
    O_INCL = 3'd3,
    O_ORIG = 3'd4
  } out_state_t;

  function automatic logic [31:0] frac_conv(input logic [31:0] ns, input bit nsec_res);
    logic [31:0] v;
    if (nsec_res) begin
      v = ns;
    end else begin
      v = ns / 32'd1000;
    end
    return v;
  endfunction

  function automatic logic [31:0] incl_len_f(input logic [15:0] len, input logic [15:0] snap);
    logic [31:0] v;
    if (len > snap) begin
      v = {16'd0, snap};
    end else begin
      v = {16'd0, len};
    end
    return v;
  endfunction

endpackage

// File: rtl/rec_fifo.sv
`timescale 1ns/1ps
// Record buffer: power-of-two FIFO with a one-entry lookahead port so the
// reader can start the next record in the same cycle it pops the current one.
module rec_fifo
  import pcap_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = pcap_rec_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_wr_en,
  input  T                         i_wr_data,
  input  logic                     i_rd_en,
  output T                         o_rd_data,
  output T                         o_rd_data_nxt,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full        = (r_count == CNT_FULL);
  assign o_empty       = (r_count == '0);
  assign o_count       = r_count;
  assign w_pop         = i_rd_en && !o_empty;
  // A write into a full buffer is still taken when a pop frees a slot this cycle.
  assign w_push        = i_wr_en && (!o_full || w_pop);
  assign o_rd_data     = r_mem[r_rd_ptr];
  assign o_rd_data_nxt = r_mem[r_rd_ptr + PTR_ONE];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pcap_rec_hdr.sv
`timescale 1ns/1ps
// Pcap record-header generator: timestamps a frame on sop, builds the
// 16-byte per-packet header on eop and streams it as four 32-bit words.
module pcap_rec_hdr
  import pcap_pkg::*;
#(
  parameter int NSEC_RES = 1,
  parameter int SNAPLEN  = 65535,
  parameter int DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] seconds,
  input  logic [31:0] nanoseconds,
  input  logic        sop,
  input  logic        eop,
  input  logic [15:0] pkt_len,
  output logic [31:0] hdr_data,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic        hdr_last,
  output logic        err,
  output logic [15:0] drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SNAP_EFF = (SNAPLEN > PCAP_MAX_SNAPLEN) ? PCAP_MAX_SNAPLEN :
                            ((SNAPLEN < 1) ? 1 : SNAPLEN);
  localparam logic [15:0]   SNAP16  = 16'(SNAP_EFF);
  localparam bit            NSEC_B  = (NSEC_RES != 0);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  cap_state_t    r_cap_state;
  cap_state_t    w_cap_nxt;
  out_state_t    r_out_state;
  out_state_t    w_out_nxt;
  logic [31:0]   r_ts_sec;
  logic [31:0]   r_ts_frac;
  logic [31:0]   w_frac_now;
  logic          w_complete;
  logic          w_err;
  logic          r_err;
  logic          r_wr_pend;
  pcap_rec_t     r_wr_rec;
  pcap_rec_t     w_rec;
  logic [15:0]   r_drop_cnt;
  logic [31:0]   r_hdr_data;
  logic [31:0]   w_hdr_data_nxt;
  logic          r_hdr_valid;
  logic          w_hdr_valid_nxt;
  logic          r_hdr_last;
  logic          w_hdr_last_nxt;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_more;
  logic [CW-1:0] w_count;
  pcap_rec_t     w_head;
  pcap_rec_t     w_head_nxt;
  pcap_rec_t     w_src;

  assign w_frac_now = frac_conv(nanoseconds, NSEC_B);
  assign w_pop      = (r_out_state == O_ORIG) && hdr_ready;
  assign w_more     = (w_count > CNT_ONE);

  assign hdr_data  = r_hdr_data;
  assign hdr_valid = r_hdr_valid;
  assign hdr_last  = r_hdr_last;
  assign err       = r_err;
  assign drop_cnt  = r_drop_cnt;

  rec_fifo #(
    .DEPTH (DEPTH),
    .T     (pcap_rec_t)
  ) u_fifo (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_wr_en       (r_wr_pend),
    .i_wr_data     (r_wr_rec),
    .i_rd_en       (w_pop),
    .o_rd_data     (w_head),
    .o_rd_data_nxt (w_head_nxt),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_count       (w_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap_state <= C_IDLE;
    end else begin
      r_cap_state <= w_cap_nxt;
    end
  end

  always_comb begin
    w_cap_nxt = r_cap_state;
    case (r_cap_state)
      C_IDLE: begin
        if (sop && !eop) begin
          w_cap_nxt = C_PKT;
        end else begin
          w_cap_nxt = C_IDLE;
        end
      end
      C_PKT: begin
        if (eop && !sop) begin
          w_cap_nxt = C_IDLE;
        end else begin
          w_cap_nxt = C_PKT;
        end
      end
      default: w_cap_nxt = C_IDLE;
    endcase
  end

  // A one-cycle frame in C_IDLE takes its timestamp straight from the inputs.
  always_comb begin
    w_complete   = 1'b0;
    w_err        = 1'b0;
    w_rec        = '0;
    case (r_cap_state)
      C_IDLE: begin
        w_complete    = sop && eop;
        w_err         = eop && !sop;
        w_rec.ts_sec  = seconds;
        w_rec.ts_frac = w_frac_now;
      end
      C_PKT: begin
        w_complete    = eop;
        w_err         = sop && !eop;
        w_rec.ts_sec  = r_ts_sec;
        w_rec.ts_frac = r_ts_frac;
      end
      default: begin
        w_complete = 1'b0;
        w_err      = 1'b0;
      end
    endcase
    w_rec.incl_len = incl_len_f(pkt_len, SNAP16);
    w_rec.orig_len = {16'd0, pkt_len};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ts_sec   <= 32'd0;
      r_ts_frac  <= 32'd0;
      r_wr_pend  <= 1'b0;
      r_wr_rec   <= '0;
      r_err      <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (sop) begin
        r_ts_sec  <= seconds;
        r_ts_frac <= w_frac_now;
      end
      r_wr_pend <= w_complete;
      if (w_complete) begin
        r_wr_rec <= w_rec;
      end
      r_err <= w_err;
      if (r_wr_pend && w_full && !w_pop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_state <= O_IDLE;
      r_hdr_data  <= 32'd0;
      r_hdr_valid <= 1'b0;
      r_hdr_last  <= 1'b0;
    end else begin
      r_out_state <= w_out_nxt;
      r_hdr_data  <= w_hdr_data_nxt;
      r_hdr_valid <= w_hdr_valid_nxt;
      r_hdr_last  <= w_hdr_last_nxt;
    end
  end

  always_comb begin
    w_out_nxt = r_out_state;
    case (r_out_state)
      O_IDLE: begin
        if (!w_empty) begin
          w_out_nxt = O_SEC;
        end else begin
          w_out_nxt = O_IDLE;
        end
      end
      O_SEC:  w_out_nxt = hdr_ready ? O_FRAC : O_SEC;
      O_FRAC: w_out_nxt = hdr_ready ? O_INCL : O_FRAC;
      O_INCL: w_out_nxt = hdr_ready ? O_ORIG : O_INCL;
      O_ORIG: begin
        if (hdr_ready) begin
          w_out_nxt = w_more ? O_SEC : O_IDLE;
        end else begin
          w_out_nxt = O_ORIG;
        end
      end
      default: w_out_nxt = O_IDLE;
    endcase
  end

  // Leaving O_ORIG pops the head, so the next record is read via the lookahead port.
  always_comb begin
    w_hdr_data_nxt  = 32'd0;
    w_hdr_valid_nxt = 1'b0;
    w_hdr_last_nxt  = 1'b0;
    if (r_out_state == O_ORIG) begin
      w_src = w_head_nxt;
    end else begin
      w_src = w_head;
    end
    case (w_out_nxt)
      O_SEC: begin
        w_hdr_data_nxt  = w_src.ts_sec;
        w_hdr_valid_nxt = 1'b1;
      end
      O_FRAC: begin
        w_hdr_data_nxt  = w_src.ts_frac;
        w_hdr_valid_nxt = 1'b1;
      end
      O_INCL: begin
        w_hdr_data_nxt  = w_src.incl_len;
        w_hdr_valid_nxt = 1'b1;
      end
      O_ORIG: begin
        w_hdr_data_nxt  = w_src.orig_len;
        w_hdr_valid_nxt = 1'b1;
        w_hdr_last_nxt  = 1'b1;
      end
      default: begin
        w_hdr_data_nxt  = 32'd0;
        w_hdr_valid_nxt = 1'b0;
        w_hdr_last_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/pcap_rec_hdr.md
PCAP_REC_HDR -- requirements
Module: pcap_rec_hdr

Interface
REQ-001 Parameter NSEC_RES, default 1: 1 = fraction word carries nanoseconds; 0 = fraction word carries microseconds (nanoseconds / 1000, truncated).
REQ-002 Parameter SNAPLEN, default 65535: maximum captured length in bytes, range 1..65535.
REQ-003 Parameter DEPTH, default 4: number of completed records buffered, power of two, minimum 2.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 seconds  in  32  free-running timestamp, seconds part.
REQ-007 nanoseconds  in  32  free-running timestamp, sub-second part, 0..999_999_999.
REQ-008 sop  in  1  one-cycle pulse: first byte of a frame seen on the wire.
REQ-009 eop  in  1  one-cycle pulse: last byte of a frame seen.
REQ-010 pkt_len  in  16  original frame length in bytes; valid when eop=1.
REQ-011 hdr_data  out  32  current pcap record-header word.
REQ-012 hdr_valid  out  1  hdr_data is valid.
REQ-013 hdr_ready  in  1  downstream accepts the word when hdr_valid and hdr_ready are both 1.
REQ-014 hdr_last  out  1  high with the 4th word of a record.
REQ-015 err  out  1  one-cycle pulse on a framing error.
REQ-016 drop_cnt  out  16  saturating count of records dropped because the buffer was full.

Function
REQ-017 The capture FSM has two states, C_IDLE and C_PKT.
REQ-018 In C_IDLE, sop latches {seconds, fraction} and moves the FSM to C_PKT.
REQ-019 sop and eop together in C_IDLE form a one-cycle frame: the timestamp is latched and the record completes in that same cycle; the FSM stays in C_IDLE.
REQ-020 eop in C_PKT completes the record and returns the FSM to C_IDLE.
REQ-021 sop and eop together in C_PKT: eop completes the current record, sop latches a new timestamp, and the FSM stays in C_PKT.
REQ-022 sop alone in C_PKT: the pending record is discarded, the new timestamp is latched, and err pulses.
REQ-023 eop in C_IDLE without sop is ignored, and err pulses.
REQ-024 Completing a record writes {ts_sec, ts_frac, incl_len, orig_len} into the buffer on the next rising edge.
  - orig_len = zero-extended pkt_len.
  - incl_len = min(pkt_len, SNAPLEN).
REQ-025 If a record completes while the buffer holds DEPTH entries, the record is dropped and drop_cnt increments; drop_cnt saturates at 0xFFFF.
REQ-026 The output FSM has five states: O_IDLE, O_SEC, O_FRAC, O_INCL, O_ORIG.
  - O_IDLE moves to O_SEC when the buffer is non-empty.
  - Each later state advances only on handshake.
  - After the O_ORIG handshake, the record is popped and the FSM goes to O_SEC if more records remain, else O_IDLE.
REQ-027 hdr_valid is 1 in states O_SEC..O_ORIG only; hdr_data and hdr_valid are registered and stay stable while hdr_valid=1 and hdr_ready=0.
REQ-028 Latency: eop at edge N gives a buffer write at N+1 and hdr_valid=1 with the O_SEC word at N+2 at the earliest, when the output FSM is idle.
REQ-029 With hdr_ready held at 1, consecutive records stream back-to-back at 4 words per 4 cycles, with no idle cycle between records.
REQ-030 Buffer pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle when full is allowed: the push is accepted and nothing is dropped.
REQ-031 When NSEC_RES=0, the divide by 1000 is applied at latch time, so the stored fraction is already in microseconds.

Reset
REQ-032 While reset_n=0, and asynchronously on its assertion, the following are cleared:
  - capture FSM to C_IDLE, output FSM to O_IDLE;
  - buffer emptied;
  - latched timestamp cleared to 0;
  - hdr_valid=0, hdr_last=0, hdr_data=0, err=0, drop_cnt=0.
REQ-033 Reset asserted mid-record discards all pending and partially emitted records; after release the block starts clean, with no partial record emitted.

Structure
REQ-034 A shared package pcap_pkg holds the record typedef (four 32-bit fields), the capture and output state enums, and the constant PCAP_MAX_SNAPLEN=65535.
REQ-035 The record buffer is a sub-module rec_fifo.
  - Parameterised by DEPTH and element type.
  - Synchronous write and read, with full/empty flags.
  - Same clk and reset_n.

Verification
REQ-036 Single frame: with reset released and hdr_ready=1, sop at ts=(5 s, 123_456_789 ns), eop with pkt_len=60 -> words 5, 123_456_789, 60, 60; hdr_last on the 4th; first word at eop+2.
REQ-037 Microsecond mode with snap: NSEC_RES=0, SNAPLEN=128; sop at (0 s, 999_999_999 ns), pkt_len=1514 -> words 0, 999_999, 128, 1514.
REQ-038 Backpressure: hdr_ready=0 for 10 cycles mid-record -> hdr_data held constant; no word lost or duplicated; 4 words emitted in order.
REQ-039 Overflow: DEPTH=4, hdr_ready=0, 6 single-cycle frames (sop and eop together) -> 4 records buffered; drop_cnt=2; then hdr_ready=1 -> 16 words; hdr_last asserted 4 times.
REQ-040 Framing errors:
  - sop, then sop again 3 cycles later -> err pulse; the record carries the second timestamp.
  - A stray eop in C_IDLE -> err pulse; no record emitted.
REQ-041 Reset mid-emission: reset_n low during the O_FRAC word -> hdr_valid=0 immediately; after release, no output until a new sop/eop pair.
